csa_resolver_seq: RTL
=====================

Name: csa_resolver_seq

Overview:
- Converts a redundant carry-save pair (sum vector, carry vector) back to plain binary. This is the inverse of the 3:2 encoder stage.
- Resolves one Chunk-bit slice per clock with a narrow adder and a registered ripple carry between slices. This trades latency for area versus a full-width lookahead adder.
- Sits after carry-save accumulators, e.g. multi-operand frequency/phase sums, where full-width carry resolution every cycle is not needed.
- Valid/ready handshake on both sides; one operand in flight at a time.

Parameters:
- Width, 32, operand/result width; must be an integer multiple of Chunk.
- Chunk, 8, bits resolved per RUN cycle; N = Width/Chunk cycles per operand.

Ports:
- i_clkp  in  1  clock, rising edge.
- i_rstn  in  1  reset; synchronous, active-high (1 = reset).
- i_vld  in  1  input operand valid.
- o_rdy  out  1  block can accept an operand.
- i_d  in  Width  carry-save sum vector.
- i_c  in  Width  carry-save carry vector, weight 2 per bit (i_c[Width-1] is discarded).
- i_cin  in  1  carry-in at bit 0.
- o_vld  out  1  result valid.
- i_rdy  in  1  downstream accepts result.
- o_d  out  Width  binary result.
- o_c  out  1  carry-out of bit Width-1.
- o_busy  out  1  high in RUN or DONE.

Behaviour:
- Arithmetic: {o_c, o_d} = i_d + {i_c[Width-2:0],1'b0} + i_cin, computed over Width+1 bits. i_c[Width-1] never contributes.
- Operand registers: on accept (i_vld & o_rdy at an edge), latch i_d, the shifted i_c, and i_cin. Then slice index k=0, carry register = i_cin. Input pins are ignored until the next accept.
- States:
  - IDLE: o_rdy=1, o_vld=0, o_busy=0. Accept -> RUN.
  - RUN: each edge adds slice k of the latched d, slice k of the latched shifted c, and the carry register. It writes o_d[k*Chunk +: Chunk] and updates the carry register, then k increments. After the edge with k=N-1 -> DONE, and o_c = final carry.
  - DONE: o_vld=1, o_rdy=0. i_rdy=1 at an edge -> IDLE. i_rdy=0 -> stay, with o_d/o_c held stable.
- Latency: with accept at edge E0, o_vld is high starting from the cycle after edge E0+N (Width=32, Chunk=8: high after the 4th edge following accept).
- Throughput: one result per N+2 cycles with i_rdy held high. No accept in DONE; o_rdy is only high in IDLE.
- Unused slices of o_d keep their previous values during RUN. o_d is only meaningful while o_vld=1.
- i_vld asserted while o_rdy=0: ignored. Upstream must hold the operand; no loss, no queue.
- Reset (any state, including mid-RUN or DONE under backpressure): at the edge with i_rstn=1, the state becomes IDLE and o_vld=0, o_c=0, o_d=0, k=0, carry register=0. The in-flight operand is discarded. o_rdy=1 in the cycle after reset deasserts.
- Reset values: o_rdy=1, o_vld=0, o_busy=0, o_d=0, o_c=0.
- Simultaneous i_rstn=1 and accept: reset wins, and the operand is not captured.

Optional Feature:
- Macro: CSA_RESOLVE_BYPASS_EN.
- Defined: at accept, if i_c[Width-2:0]==0 and i_cin==0, the result is exact without any ripple. The FSM loads o_d=i_d, o_c=0 and goes directly IDLE->DONE, so o_vld is high from the cycle after the accept edge. All other operands take the normal RUN path.
- Not defined: every operand takes N RUN cycles; there is no zero-detect logic.

Test Plan:
- Width=32, Chunk=8, i_d=0x000000FF, i_c=0x00000001, i_cin=0 -> o_d=0x00000101, o_c=0, o_vld high after the 4th edge following accept.
- i_d=0xFFFFFFFF, i_c=0, i_cin=1 -> o_d=0x00000000, o_c=1; the carry ripples through all 4 slices.
- i_d=0x00000000, i_c=0x80000000, i_cin=0 -> o_d=0, o_c=0 (MSB of i_c discarded). Also i_d=0x80000000, i_c=0x40000000 -> o_d=0x00000000, o_c=1.
- Backpressure: i_rdy=0 for 5 cycles in DONE with i_vld=1 and new data toggling -> o_d/o_c/o_vld stable, o_rdy=0, no capture. i_rdy=1 -> IDLE next cycle, and the next operand is accepted.
- Reset asserted on the 2nd RUN cycle -> next cycle IDLE, o_vld=0, o_d=0, o_c=0. A following operand 0x12345678 + c=0x00000010 gives o_d=0x12345698, with no leftover carry.
- With CSA_RESOLVE_BYPASS_EN: i_d=0xDEADBEEF, i_c=0, i_cin=0 -> o_d=0xDEADBEEF, o_vld one edge after accept. Same operand with i_cin=1 -> normal 4-cycle path, o_d=0xDEADBEF0.

Source files
------------

// File: rtl/csa_resolver_seq_if.sv
// Handshake/bus interface for csa_resolver_seq.
//
// Valid/ready semantics (both directions): a transfer happens at a rising
// clock edge where valid and ready are both high. A producer that raises
// valid keeps its payload stable until that edge. Valid never waits on ready.
// The consumer may raise or drop ready freely.
//
// The slave modport is the resolver side. The master modport is the
// upstream/downstream side. dbg_state exposes the resolver FSM state.
interface csa_resolver_seq_if #(
  parameter int Width = 32
);
  logic             i_vld;
  logic             o_rdy;
  logic [Width-1:0] i_d;
  logic [Width-1:0] i_c;
  logic             i_cin;
  logic             o_vld;
  logic             i_rdy;
  logic [Width-1:0] o_d;
  logic             o_c;
  logic             o_busy;
  logic [1:0]       dbg_state;

  modport slave (
    input  i_vld, i_d, i_c, i_cin, i_rdy,
    output o_rdy, o_vld, o_d, o_c, o_busy, dbg_state
  );

  modport master (
    output i_vld, i_d, i_c, i_cin, i_rdy,
    input  o_rdy, o_vld, o_d, o_c, o_busy, dbg_state
  );
endinterface

// File: rtl/csa_resolver_seq.sv
// csa_resolver_seq: folds a carry-save pair (sum, carry) back into plain
// binary. Each RUN cycle resolves one Chunk-bit slice. A registered ripple
// carry links the slices, so one operand takes Width/Chunk RUN cycles.
//   {o_c, o_d} = i_d + {i_c[Width-2:0], 1'b0} + i_cin
// Optional macro CSA_RESOLVE_BYPASS_EN: when the operand has no carry
// content (shifted carry vector zero and i_cin zero), the sum vector is
// already the answer. The FSM then goes straight from IDLE to DONE.
module csa_resolver_seq #(
  parameter int Width = 32,
  parameter int Chunk = 8
) (
  input  logic                     i_clkp,
  input  logic                     i_rstn,
  csa_resolver_seq_if.slave        bus
);

  localparam int N  = Width / Chunk;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [Width-1:0] d_q;
  logic [Width-1:0] c_q;
  logic             cy_q;
  logic [KW-1:0]    k_q;
  logic [Width-1:0] res_d_q;
  logic             res_c_q;

  logic             accept;
  logic             last_slice;
  logic [Chunk:0]   slice_sum;
  logic             bypass_hit;

  // The top carry bit has weight 2^Width, so it never reaches the result.
  logic unused_c_msb;
  assign unused_c_msb = bus.i_c[Width-1];

  assign accept     = bus.i_vld && (state_q == IDLE);
  assign last_slice = (k_q == KW'(N - 1));

  // Narrow adder for the current slice, including the rippled carry.
  assign slice_sum = {1'b0, d_q[k_q*Chunk +: Chunk]}
                   + {1'b0, c_q[k_q*Chunk +: Chunk]}
                   + {{Chunk{1'b0}}, cy_q};

`ifdef CSA_RESOLVE_BYPASS_EN
  assign bypass_hit = (bus.i_c[Width-2:0] == '0) && !bus.i_cin;
`else
  assign bypass_hit = 1'b0;
`endif

  // State register; reset discards any in-flight operand.
  always_ff @(posedge i_clkp) begin
    if (i_rstn) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d    = state_q;
    bus.o_rdy  = 1'b0;
    bus.o_vld  = 1'b0;
    bus.o_busy = 1'b0;
    case (state_q)
      IDLE: begin
        bus.o_rdy = 1'b1;
        if (accept) state_d = bypass_hit ? DONE : RUN;
      end
      RUN: begin
        bus.o_busy = 1'b1;
        if (last_slice) state_d = DONE;
      end
      DONE: begin
        bus.o_busy = 1'b1;
        bus.o_vld  = 1'b1;
        if (bus.i_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture at accept and slice-by-slice result build-up in RUN.
  always_ff @(posedge i_clkp) begin
    if (i_rstn) begin
      d_q     <= '0;
      c_q     <= '0;
      cy_q    <= 1'b0;
      k_q     <= '0;
      res_d_q <= '0;
      res_c_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            d_q  <= bus.i_d;
            c_q  <= {bus.i_c[Width-2:0], 1'b0};
            cy_q <= bus.i_cin;
            k_q  <= '0;
            if (bypass_hit) begin
              res_d_q <= bus.i_d;
              res_c_q <= 1'b0;
            end
          end
        end
        RUN: begin
          res_d_q[k_q*Chunk +: Chunk] <= slice_sum[Chunk-1:0];
          cy_q <= slice_sum[Chunk];
          k_q  <= k_q + KW'(1);
          if (last_slice) res_c_q <= slice_sum[Chunk];
        end
        default: ;
      endcase
    end
  end

  assign bus.o_d       = res_d_q;
  assign bus.o_c       = res_c_q;
  assign bus.dbg_state = state_q;

endmodule
